// File: rtl/pipe_stage.sv
// Elastic valid/ready pipeline register carrying a payload word and its next-PC,
// with flush and saturating bubble/stall counters. Define PIPE_STAGE_SKID_EN for the two-entry skid build.
module pipe_stage #(
    parameter int DATA_W = 64,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1
    } state_t;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    state_t            state_nxt;
    logic              in_beat;
    logic              load_main_in;
    logic [DATA_W-1:0] main_data;
    logic [PC_W-1:0]   main_pc;

`ifdef PIPE_STAGE_SKID_EN
    logic              load_main_skid;
    logic              load_skid;
    logic [DATA_W-1:0] skid_data;
    logic [PC_W-1:0]   skid_pc;

    // The skid entry is full only in TWO, so in_ready is a pure state decode.
    assign in_ready = (state != TWO);
`else
    assign in_ready = (state == EMPTY) | out_ready;
`endif

    assign in_beat   = in_valid & in_ready;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign out_pc    = main_pc;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        state_nxt    = state;
        load_main_in = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
`endif
        unique case (state)
            EMPTY: begin
                if (in_beat) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_beat && out_ready) begin
                    load_main_in = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
                end else if (in_beat) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
`endif
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
`ifdef PIPE_STAGE_SKID_EN
            TWO: begin
                if (out_ready) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
`endif
            default: state_nxt = EMPTY;
        endcase

        // Flush squashes valid state only; an output beat this cycle has already completed.
        if (flush) begin
            state_nxt    = EMPTY;
            load_main_in = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_data <= '0;
            main_pc   <= '0;
        end else if (load_main_in) begin
            main_data <= in_data;
            main_pc   <= in_pc;
`ifdef PIPE_STAGE_SKID_EN
        end else if (load_main_skid) begin
            main_data <= skid_data;
            main_pc   <= skid_pc;
`endif
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_data <= '0;
            skid_pc   <= '0;
        end else if (load_skid) begin
            skid_data <= in_data;
            skid_pc   <= in_pc;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     bubble_cnt <= '0;
        else if (cnt_clr)                            bubble_cnt <= '0;
        else if (!out_valid && bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                stall_cnt <= '0;
        else if (cnt_clr)                                       stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage: a reference queue and counter model are stepped each cycle.
// Works for both the default build and the PIPE_STAGE_SKID_EN build.
module tb_pipe_stage;
    localparam int DATA_W = 64;
    localparam int PC_W   = 32;
    localparam int CNT_W  = 16;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   pc;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic              cnt_clr = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic [PC_W-1:0]   in_pc = '0;

    logic              in_ready, out_valid;
    logic [DATA_W-1:0] out_data;
    logic [PC_W-1:0]   out_pc;
    logic [CNT_W-1:0]  bubble_cnt, stall_cnt;

    logic              sat_in_ready, sat_out_valid;
    logic [DATA_W-1:0] sat_out_data;
    logic [PC_W-1:0]   sat_out_pc;
    logic [1:0]        sat_bubble_cnt, sat_stall_cnt;

    pipe_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_pc(out_pc),
        .cnt_clr(cnt_clr), .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
    );

    pipe_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data), .in_pc(in_pc),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data), .out_pc(sat_out_pc),
        .cnt_clr(cnt_clr), .bubble_cnt(sat_bubble_cnt), .stall_cnt(sat_stall_cnt)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    beat_t       sb[$];
    logic [15:0] m_bub = '0;
    logic [15:0] m_stall = '0;
    logic [1:0]  s_bub = '0;
    logic [1:0]  s_stall = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_bub = '0; m_stall = '0; s_bub = '0; s_stall = '0;
    endtask

    // One clock: compare pre-edge outputs with the model, advance the model, compare counters after the edge.
    task automatic cycle();
        logic  exp_ov, exp_ir;
        beat_t head;
        #1;
        exp_ov = (sb.size() != 0);
`ifdef PIPE_STAGE_SKID_EN
        exp_ir = (sb.size() < 2);
`else
        exp_ir = (sb.size() == 0) || out_ready;
`endif
        check("out_valid", out_valid, exp_ov);
        check("in_ready", in_ready, exp_ir);
        check("sat_out_valid", sat_out_valid, exp_ov);
        check("sat_in_ready", sat_in_ready, exp_ir);
        if (exp_ov) begin
            head = sb[0];
            check("out_data", out_data, head.data);
            check("out_pc", out_pc, head.pc);
            check("sat_out_pc", sat_out_pc, head.pc);
            check("sat_out_data", sat_out_data, head.data);
            if (out_ready) void'(sb.pop_front());
        end
        if (flush) sb.delete();
        else if (in_valid && exp_ir) sb.push_back({in_data, in_pc});
        if (cnt_clr) begin
            m_bub = '0; m_stall = '0; s_bub = '0; s_stall = '0;
        end else begin
            if (!exp_ov) begin
                if (m_bub != 16'hFFFF) m_bub++;
                if (s_bub != 2'd3) s_bub++;
            end
            if (exp_ov && !out_ready) begin
                if (m_stall != 16'hFFFF) m_stall++;
                if (s_stall != 2'd3) s_stall++;
            end
        end
        @(posedge clk);
        #1;
        check("bubble_cnt", bubble_cnt, m_bub);
        check("stall_cnt", stall_cnt, m_stall);
        check("sat_bubble_cnt", sat_bubble_cnt, s_bub);
        check("sat_stall_cnt", sat_stall_cnt, s_stall);
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [PC_W-1:0] p, input logic r);
        in_valid = v; in_data = d; in_pc = p; out_ready = r;
    endtask

    initial begin
        // Power-on reset values, observed while rst is still high
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_data", out_data, '0);
        check("rst_out_pc", out_pc, '0);
        check("rst_bubble", bubble_cnt, '0);
        check("rst_stall", stall_cnt, '0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        // Reset mid-stream while holding 0xDEAD: outputs clear without a clock edge
        drive(1'b0, '0, '0, 1'b0);
        cycle();
        drive(1'b1, 64'hDEAD, 32'h100, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b0);
        #1;
        check("pre_rst_data", out_data, 64'hDEAD);
        rst = 1'b1;
        #1;
        check("async_out_valid", out_valid, 1'b0);
        check("async_out_data", out_data, '0);
        check("async_in_ready", in_ready, 1'b1);
        check("async_bubble", bubble_cnt, '0);
        check("async_stall", stall_cnt, '0);
        rst = 1'b0;
        model_reset();
        cycle();

        // Streaming: eight back-to-back beats at full rate
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, {$urandom, $urandom}, 32'(i * 4), 1'b1);
            cycle();
        end
        drive(1'b0, '0, '0, 1'b1);
        cycle();
        check("stream_stall", stall_cnt, '0);
        check("stream_drained", out_valid, 1'b0);

        // Back-pressure: A accepted, B offered while downstream stalls
        drive(1'b1, 64'hA, 32'hA0, 1'b0);
        cycle();
        drive(1'b1, 64'hB, 32'hB0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
        cycle();
        check("bp_in_ready_full", in_ready, 1'b0);
        check("bp_head_is_a", out_data, 64'hA);
        drive(1'b0, '0, '0, 1'b0);
        cycle();
`else
        #1;
        check("bp_in_ready_comb0", in_ready, 1'b0);
        cycle();
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_comb1", in_ready, 1'b1);
        cycle();
`endif
        drive(1'b0, '0, '0, 1'b1);
        cycle();
        cycle();
        check("bp_drained", out_valid, 1'b0);

        // Flush with the stage full and an input beat offered
        drive(1'b1, 64'hC, 32'hC0, 1'b0);
        cycle();
`ifdef PIPE_STAGE_SKID_EN
        drive(1'b1, 64'hD, 32'hD0, 1'b0);
        cycle();
`endif
        drive(1'b1, 64'hE, 32'hE0, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("flush_empty", out_valid, 1'b0);
        drive(1'b0, '0, '0, 1'b1);
        cycle();
        cycle();

        // Flush while the head beat is leaving: that beat still completes
        drive(1'b1, 64'hF, 32'hF0, 1'b0);
        cycle();
        drive(1'b1, 64'h6, 32'h60, 1'b1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(1'b0, '0, '0, 1'b1);
        cycle();

        // Counter saturation on the 2-bit instance and synchronous clear
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        repeat (6) cycle();
        check("sat_bubble_held", sat_bubble_cnt, 2'd3);
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
        check("sat_bubble_clr", sat_bubble_cnt, 2'd0);
        drive(1'b1, 64'h77, 32'h70, 1'b0);
        cycle();
        drive(1'b0, '0, '0, 1'b0);
        repeat (5) cycle();
        check("sat_stall_held", sat_stall_cnt, 2'd3);
        out_ready = 1'b1;
        cycle();

        // Randomised traffic with occasional flush and clear
        repeat (300) begin
            drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, $urandom, 1'($urandom_range(0, 1)));
            flush   = ($urandom_range(0, 15) == 0);
            cnt_clr = ($urandom_range(0, 31) == 0);
            cycle();
        end
        flush = 1'b0;
        cnt_clr = 1'b0;
        drive(1'b0, '0, '0, 1'b1);
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
